// File: rtl/adc_capture_seq.sv
// ADC capture sequencer: re-arms the trigger block, cuts its stream into tlast-terminated
// records separated by a holdoff, and forwards beats through a one-deep output buffer.
module adc_capture_seq #(
   parameter int unsigned REC_WIDTH    = 32,
   parameter int unsigned HOLD_WIDTH   = 16,
   parameter int unsigned REARM_CYCLES = 4
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cfg_arm,
   input  logic                  cfg_abort,
   input  logic [REC_WIDTH-1:0]  cfg_record_len,
   input  logic [15:0]           cfg_num_records,
   input  logic [HOLD_WIDTH-1:0] cfg_holdoff,
   output logic                  adc_reset_trigger,
   output logic                  adc_reset_max_sum,
   input  logic                  s_axis_tvalid,
   input  logic [63:0]           s_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [63:0]           m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [2:0]            sts_state,
   output logic [15:0]           sts_records,
   output logic                  sts_overflow,
   output logic                  sts_busy
);

   localparam int unsigned RearmW = (REARM_CYCLES < 2) ? 1 : $clog2(REARM_CYCLES + 1);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StRearm    = 3'd1,
      StWaitTrig = 3'd2,
      StCapture  = 3'd3,
      StHoldoff  = 3'd4,
      StDone     = 3'd5
   } state_e;

   state_e                r_state,     w_state_nx;
   logic [RearmW-1:0]     r_rearm_cnt, w_rearm_nx;
   logic [REC_WIDTH-1:0]  r_beat_cnt,  w_beat_nx;
   logic [HOLD_WIDTH-1:0] r_hold_cnt,  w_hold_nx;
   logic [15:0]           r_records,   w_records_nx;
   logic                  r_overflow,  w_overflow_nx;
   logic                  r_trig,      w_trig_nx;
   logic                  r_max_sum,   w_max_sum_nx;
   logic                  r_tvalid,    w_tvalid_nx;
   logic [63:0]           r_tdata,     w_tdata_nx;
   logic                  r_tlast,     w_tlast_nx;

   logic [REC_WIDTH-1:0]  w_rec_len;
   logic [HOLD_WIDTH-1:0] w_hold_len;
   logic [REC_WIDTH-1:0]  w_beat_num;
   logic [15:0]           w_rec_inc;
   logic                  w_in_window;
   logic                  w_beat;
   logic                  w_end_rec;
   logic                  w_buf_free;

   assign w_rec_len   = (cfg_record_len == '0) ? REC_WIDTH'(1) : cfg_record_len;
   assign w_hold_len  = (cfg_holdoff == '0) ? HOLD_WIDTH'(1) : cfg_holdoff;
   assign w_in_window = (r_state == StWaitTrig) || (r_state == StCapture);
   assign w_beat      = w_in_window && s_axis_tvalid;
   // The triggering beat in WAIT_TRIG is always beat 1 of the record.
   assign w_beat_num  = (r_state == StWaitTrig) ? REC_WIDTH'(1) : r_beat_cnt + REC_WIDTH'(1);
   assign w_end_rec   = w_beat && (w_beat_num == w_rec_len);
   assign w_rec_inc   = (r_records == 16'hFFFF) ? r_records : r_records + 16'd1;
   assign w_buf_free  = !r_tvalid || m_axis_tready;

   always_comb begin
      w_state_nx    = r_state;
      w_rearm_nx    = r_rearm_cnt;
      w_beat_nx     = r_beat_cnt;
      w_hold_nx     = r_hold_cnt;
      w_records_nx  = r_records;
      w_overflow_nx = r_overflow;
      w_max_sum_nx  = 1'b0;
      w_tvalid_nx   = r_tvalid;
      w_tdata_nx    = r_tdata;
      w_tlast_nx    = r_tlast;

      if (r_tvalid && m_axis_tready) begin
         w_tvalid_nx = 1'b0;
         w_tlast_nx  = 1'b0;
      end
      // A beat that cannot be buffered is lost but still counts toward the record.
      if (w_beat) begin
         if (w_buf_free) begin
            w_tvalid_nx = 1'b1;
            w_tdata_nx  = s_axis_tdata;
            w_tlast_nx  = w_end_rec;
         end else begin
            w_overflow_nx = 1'b1;
         end
      end

      unique case (r_state)
         StIdle, StDone: begin
            if (cfg_arm) begin
               w_state_nx    = StRearm;
               w_rearm_nx    = RearmW'(REARM_CYCLES);
               w_records_nx  = '0;
               w_overflow_nx = 1'b0;
               w_max_sum_nx  = 1'b1;
            end
         end
         StRearm: begin
            w_rearm_nx = r_rearm_cnt - RearmW'(1);
            if (r_rearm_cnt <= RearmW'(1)) begin
               w_state_nx = StWaitTrig;
            end
         end
         StWaitTrig, StCapture: begin
            if (w_beat) begin
               w_state_nx = StCapture;
               w_beat_nx  = w_beat_num;
               if (w_end_rec) begin
                  w_beat_nx    = '0;
                  w_records_nx = w_rec_inc;
                  if ((cfg_num_records != 16'd0) && (w_rec_inc == cfg_num_records)) begin
                     w_state_nx = StDone;
                  end else begin
                     w_state_nx = StHoldoff;
                     w_hold_nx  = w_hold_len;
                  end
               end
            end
         end
         StHoldoff: begin
            w_hold_nx = r_hold_cnt - HOLD_WIDTH'(1);
            if (r_hold_cnt <= HOLD_WIDTH'(1)) begin
               w_state_nx = StWaitTrig;
            end
         end
         default: w_state_nx = StIdle;
      endcase

      // Abort overrides everything, including a simultaneous arm or record completion.
      if (cfg_abort) begin
         w_state_nx    = StIdle;
         w_beat_nx     = '0;
         w_records_nx  = r_records;
         w_overflow_nx = r_overflow;
         w_max_sum_nx  = 1'b0;
         w_tvalid_nx   = 1'b0;
         w_tlast_nx    = 1'b0;
      end

      w_trig_nx = !((w_state_nx == StWaitTrig) || (w_state_nx == StCapture));
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state     <= StIdle;
         r_rearm_cnt <= '0;
         r_beat_cnt  <= '0;
         r_hold_cnt  <= '0;
         r_records   <= '0;
         r_overflow  <= 1'b0;
         r_trig      <= 1'b1;
         r_max_sum   <= 1'b0;
         r_tvalid    <= 1'b0;
         r_tdata     <= '0;
         r_tlast     <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_rearm_cnt <= w_rearm_nx;
         r_beat_cnt  <= w_beat_nx;
         r_hold_cnt  <= w_hold_nx;
         r_records   <= w_records_nx;
         r_overflow  <= w_overflow_nx;
         r_trig      <= w_trig_nx;
         r_max_sum   <= w_max_sum_nx;
         r_tvalid    <= w_tvalid_nx;
         r_tdata     <= w_tdata_nx;
         r_tlast     <= w_tlast_nx;
      end
   end

   assign adc_reset_trigger = r_trig;
   assign adc_reset_max_sum = r_max_sum;
   assign m_axis_tvalid     = r_tvalid;
   assign m_axis_tdata      = r_tdata;
   assign m_axis_tlast      = r_tlast;
   assign sts_state         = r_state;
   assign sts_records       = r_records;
   assign sts_overflow      = r_overflow;
   assign sts_busy          = (r_state == StRearm) || (r_state == StWaitTrig) ||
                              (r_state == StCapture) || (r_state == StHoldoff);

endmodule
